// File: rtl/serial_bit_streamer.sv
// rtl/serial_bit_streamer.sv - parallel-to-serial bit streamer with payload qualifier and optional inter-word gap
module serial_bit_streamer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] W_C      = CW'(WIDTH);
  localparam logic [CW-1:0] W_M1_C   = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_C    = GW'(GAP);
  localparam bit            HAS_GAP  = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             word_done_q, word_done_d;
  logic             last_bit;
  logic             accept;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    x_d         = IDLE_BIT;
    x_valid_d   = 1'b0;
    word_done_d = 1'b0;

    last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == W_C);
    // With no gap the last-bit cycle doubles as an acceptance slot so words stream without a bubble
    din_ready = reset && ((state_q == ST_IDLE) || (last_bit && !HAS_GAP));
    accept    = din_valid && din_ready;

    case (state_q)
      ST_IDLE: begin
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          x_d         = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
          sreg_d      = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          bit_cnt_d   = bit_cnt_q + CW'(1);
          x_valid_d   = 1'b1;
          word_done_d = (bit_cnt_q == W_M1_C);
        end else if (HAS_GAP) begin
          state_d   = ST_GAP;
          gap_cnt_d = GW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_C) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      x_d         = MSB_FIRST ? din[WIDTH-1] : din[0];
      sreg_d      = MSB_FIRST ? (din << 1) : (din >> 1);
      bit_cnt_d   = CW'(1);
      x_valid_d   = 1'b1;
      word_done_d = 1'b0;
      state_d     = ST_SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_bit_streamer.sv
// tb/tb_serial_bit_streamer.sv - directed self-checking bench for serial_bit_streamer
module tb_serial_bit_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: WIDTH=6 MSB-first no gap; b: WIDTH=8 LSB-first GAP=3; c: WIDTH=4 IDLE_BIT=1
  logic       ra, dva, rdya, xa, xva, wda, busya;
  logic [5:0] dina;
  logic       rb, dvb, rdyb, xb, xvb, wdb, busyb;
  logic [7:0] dinb;
  logic       rc, dvc, rdyc, xc, xvc, wdc, busyc;
  logic [3:0] dinc;

  logic [11:0] stream;
  logic [7:0]  wordb;

  serial_bit_streamer #(.WIDTH(6), .GAP(0), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .reset(ra), .din(dina), .din_valid(dva), .din_ready(rdya),
    .x(xa), .x_valid(xva), .word_done(wda), .busy(busya));

  serial_bit_streamer #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .reset(rb), .din(dinb), .din_valid(dvb), .din_ready(rdyb),
    .x(xb), .x_valid(xvb), .word_done(wdb), .busy(busyb));

  serial_bit_streamer #(.WIDTH(4), .GAP(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
    .clk(clk), .reset(rc), .din(dinc), .din_valid(dvc), .din_ready(rdyc),
    .x(xc), .x_valid(xvc), .word_done(wdc), .busy(busyc));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ra = 1'b0; dva = 1'b0; dina = '0;
    rb = 1'b0; dvb = 1'b0; dinb = '0;
    rc = 1'b0; dvc = 1'b0; dinc = '0;
    tick();
    tick();

    chk("a_rst_x", 16'(xa), 16'd0);
    chk("a_rst_xv", 16'(xva), 16'd0);
    chk("a_rst_wd", 16'(wda), 16'd0);
    chk("a_rst_busy", 16'(busya), 16'd0);
    chk("a_rst_rdy", 16'(rdya), 16'd0);
    chk("c_rst_x", 16'(xc), 16'd1);
    chk("b_rst_rdy", 16'(rdyb), 16'd0);

    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    #1;
    chk("a_rdy_after_rst", 16'(rdya), 16'd1);
    chk("b_rdy_after_rst", 16'(rdyb), 16'd1);

    // single word, MSB first
    dina = 6'b110101; dva = 1'b1;
    tick();
    dva = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("a1_x%0d", i), 16'(xa), 16'(dina[5-i]));
      chk($sformatf("a1_xv%0d", i), 16'(xva), 16'd1);
      chk($sformatf("a1_wd%0d", i), 16'(wda), 16'(i == 5));
      chk($sformatf("a1_rdy%0d", i), 16'(rdya), 16'(i == 5));
      chk($sformatf("a1_busy%0d", i), 16'(busya), 16'd1);
      tick();
    end
    chk("a1_end_xv", 16'(xva), 16'd0);
    chk("a1_end_x", 16'(xa), 16'd0);
    chk("a1_end_busy", 16'(busya), 16'd0);
    chk("a1_end_rdy", 16'(rdya), 16'd1);

    // back-to-back words with din_valid held; din changes mid-word
    stream = 12'b110101_000111;
    dina = 6'b110101; dva = 1'b1;
    tick();
    dina = 6'b000111;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("a2_x%0d", i), 16'(xa), 16'(stream[11-i]));
      chk($sformatf("a2_xv%0d", i), 16'(xva), 16'd1);
      chk($sformatf("a2_rdy%0d", i), 16'(rdya), 16'((i == 5) || (i == 11)));
      chk($sformatf("a2_wd%0d", i), 16'(wda), 16'((i == 5) || (i == 11)));
      tick();
      if (i == 5) dva = 1'b0;
    end
    chk("a2_end_xv", 16'(xva), 16'd0);
    chk("a2_end_busy", 16'(busya), 16'd0);

    // reset on the 3rd payload cycle aborts the word
    dina = 6'b111111; dva = 1'b1;
    tick();
    dva = 1'b0;
    tick();
    tick();
    chk("a3_mid_xv", 16'(xva), 16'd1);
    ra = 1'b0;
    #1;
    chk("a3_rdy_in_rst", 16'(rdya), 16'd0);
    tick();
    chk("a3_x", 16'(xa), 16'd0);
    chk("a3_xv", 16'(xva), 16'd0);
    chk("a3_busy", 16'(busya), 16'd0);
    chk("a3_wd", 16'(wda), 16'd0);
    chk("a3_rdy_held", 16'(rdya), 16'd0);
    ra = 1'b1;
    #1;
    chk("a3_rdy_rel", 16'(rdya), 16'd1);
    tick();
    chk("a3_no_resume", 16'(xva), 16'd0);

    // LSB first with a 3-cycle gap; request held through SHIFT and GAP
    wordb = 8'hA5;
    dinb = 8'hA5; dvb = 1'b1;
    tick();
    dinb = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_x%0d", i), 16'(xb), 16'(wordb[i]));
      chk($sformatf("b_xv%0d", i), 16'(xvb), 16'd1);
      chk($sformatf("b_rdy%0d", i), 16'(rdyb), 16'd0);
      chk($sformatf("b_wd%0d", i), 16'(wdb), 16'(i == 7));
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("b_gap_x%0d", g), 16'(xb), 16'd0);
      chk($sformatf("b_gap_xv%0d", g), 16'(xvb), 16'd0);
      chk($sformatf("b_gap_rdy%0d", g), 16'(rdyb), 16'd0);
      chk($sformatf("b_gap_busy%0d", g), 16'(busyb), 16'd1);
      tick();
    end
    chk("b_idle_rdy", 16'(rdyb), 16'd1);
    chk("b_idle_busy", 16'(busyb), 16'd0);
    chk("b_idle_xv", 16'(xvb), 16'd0);
    tick();
    dvb = 1'b0;
    wordb = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2_x%0d", i), 16'(xb), 16'(wordb[i]));
      chk($sformatf("b2_xv%0d", i), 16'(xvb), 16'd1);
      tick();
    end
    chk("b2_end_xv", 16'(xvb), 16'd0);

    // IDLE_BIT=1 with no traffic
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("c_x%0d", i), 16'(xc), 16'd1);
      chk($sformatf("c_xv%0d", i), 16'(xvc), 16'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
